// File: rtl/xor_checksum_acc_pkg.sv
// Shared types for the frame XOR checksum accumulator.
// State encoding and counter-width derivation live here.
package xor_checksum_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Word counter needs at least one bit even for single-word frames.
  function automatic int cnt_width(input int frame_len);
    int w;
    w = $clog2(frame_len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/xor_checksum_acc_if.sv
// Handshake bundle between a word producer / result consumer
// and the XOR checksum accumulator.
interface xor_checksum_acc_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);

  logic             START;
  logic [WIDTH-1:0] D;
  logic             D_VALID;
  logic             D_READY;
  logic [WIDTH-1:0] SUM;
  logic             SUM_VALID;
  logic             SUM_ACK;
  logic             BUSY;
  logic [CNT_W-1:0] COUNT;

  modport master (
    output START,
    output D,
    output D_VALID,
    input  D_READY,
    input  SUM,
    input  SUM_VALID,
    output SUM_ACK,
    input  BUSY,
    input  COUNT
  );

  modport slave (
    input  START,
    input  D,
    input  D_VALID,
    output D_READY,
    output SUM,
    output SUM_VALID,
    input  SUM_ACK,
    output BUSY,
    output COUNT
  );

endinterface

// File: rtl/xor_checksum_acc_xor4_stage.sv
// Combinational bitwise XOR of two words.
// Maps onto one 74x86 per four bits.
module xor4_stage #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_checksum_acc.sv
// Frame-based XOR checksum accumulator: folds FRAME_LEN words,
// then holds the checksum until the consumer acknowledges it.
module xor_checksum_acc
  import xor_checksum_acc_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 8
) (
  input logic               CLK,
  input logic               RST,
  xor_checksum_acc_if.slave bus
);

  localparam int CNT_W = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_x;
  logic [WIDTH-1:0] sum;
  logic             sum_valid;
  logic [CNT_W-1:0] count;
  logic             d_ready;
  logic             xfer;
  logic             last;

  xor4_stage #(
    .WIDTH(WIDTH)
  ) u_xor (
    .a(acc),
    .b(bus.D),
    .y(acc_x)
  );

  assign xfer = bus.D_VALID & d_ready;
  assign last = (count == LAST_IDX);

  always_comb begin
    d_ready = 1'b0;
    unique case (1'b1)
      (state == ST_ACCUM): d_ready = 1'b1;
      default:             d_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.START) state_nx = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (xfer && last) state_nx = ST_DONE;
      end
      // START alongside SUM_ACK only returns to IDLE
      ST_DONE: begin
        if (bus.SUM_ACK) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc       <= '0;
      count     <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.START) begin
            acc   <= '0;
            count <= '0;
          end
        end
        ST_ACCUM: begin
          if (xfer) begin
            acc <= acc_x;
            if (last) begin
              sum       <= acc_x;
              sum_valid <= 1'b1;
              count     <= '0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (bus.SUM_ACK) sum_valid <= 1'b0;
        end
        default: begin
          sum_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.D_READY   = d_ready;
  assign bus.BUSY      = (state != ST_IDLE);
  assign bus.SUM       = sum;
  assign bus.SUM_VALID = sum_valid;
  assign bus.COUNT     = count;

endmodule

// File: tb/tb_xor_checksum_acc.sv
// Scoreboard bench for the XOR checksum accumulator:
// an 8-word build plus a single-word build on a shared reset.
module tb_xor_checksum_acc;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  xor_checksum_acc_if #(.WIDTH(4), .CNT_W(3)) bus  ();
  xor_checksum_acc_if #(.WIDTH(4), .CNT_W(1)) bus1 ();

  xor_checksum_acc #(
    .WIDTH(4),
    .FRAME_LEN(8)
  ) u_dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  xor_checksum_acc #(
    .WIDTH(4),
    .FRAME_LEN(1)
  ) u_dut1 (
    .CLK(clk),
    .RST(rst),
    .bus(bus1)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] exp_q[$];
  logic       prev_sv = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each new result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bus.SUM_VALID && !prev_sv) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sum_unexpected: got %0h expected none", bus.SUM);
      end else begin
        check("sum", bus.SUM, exp_q.pop_front());
        check("count_at_done", bus.COUNT, 0);
      end
    end
    prev_sv = bus.SUM_VALID;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check("start_ready", bus.D_READY, 1);
    check("start_count", bus.COUNT, 0);
  endtask

  task automatic send(input logic [3:0] w);
    int k;
    k = 0;
    bus.D = w;
    bus.D_VALID = 1'b1;
    while (!bus.D_READY && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end
    tick();
  endtask

  task automatic ack_result(input int delay, input logic with_start);
    int k;
    k = 0;
    bus.D_VALID = 1'b0;
    while (!bus.SUM_VALID && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL result_timeout: got sv=0 expected sv=1");
    end
    for (int i = 0; i < delay; i++) begin
      bus.START = with_start;
      tick();
      check("done_hold_busy", bus.BUSY, 1);
    end
    bus.START = 1'b0;
    bus.SUM_ACK = 1'b1;
    tick();
    bus.SUM_ACK = 1'b0;
    check("ack_sv", bus.SUM_VALID, 0);
    check("ack_busy", bus.BUSY, 0);
  endtask

  function automatic logic [3:0] fold(input logic [3:0] w[8]);
    logic [3:0] r;
    r = 4'h0;
    foreach (w[i]) r = r ^ w[i];
    return r;
  endfunction

  logic [3:0] words[8];
  logic [3:0] c;

  initial begin
    rst = 1'b1;
    bus.START = 0; bus.D = 0; bus.D_VALID = 0; bus.SUM_ACK = 0;
    bus1.START = 0; bus1.D = 0; bus1.D_VALID = 0; bus1.SUM_ACK = 0;

    // 1: reset
    tick(); tick();
    check("rst_sum", bus.SUM, 0);
    check("rst_sv", bus.SUM_VALID, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_ready", bus.D_READY, 0);
    check("rst_count", bus.COUNT, 0);
    rst = 1'b0;
    tick();
    check("post_rst_busy", bus.BUSY, 0);
    check("post_rst_ready", bus.D_READY, 0);
    check("post_rst_count", bus.COUNT, 0);

    // asynchronous reset mid-frame
    start_frame();
    send(4'h3); send(4'h9);
    bus.D_VALID = 1'b0;
    check("pre_async_count", bus.COUNT, 2);
    #2 rst = 1'b1;
    #1;
    check("async_count", bus.COUNT, 0);
    check("async_busy", bus.BUSY, 0);
    check("async_ready", bus.D_READY, 0);
    check("async_sv", bus.SUM_VALID, 0);
    tick();
    rst = 1'b0;
    tick();

    // 2: basic back-to-back frame
    words = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'h6, 4'hF};
    exp_q.push_back(fold(words));
    start_frame();
    for (int i = 0; i < 8; i++) send(words[i]);
    bus.D_VALID = 1'b0;
    check("basic_latency", bus.SUM_VALID, 1);
    check("basic_ready", bus.D_READY, 0);
    ack_result(0, 1'b0);

    // 3: stalls on cycles 2 and 5
    exp_q.push_back(fold(words));
    start_frame();
    for (int i = 0; i < 8; i++) begin
      if (i == 2 || i == 5) begin
        bus.D_VALID = 1'b0;
        c = bus.COUNT;
        tick();
        check("stall_count", bus.COUNT, c);
        check("stall_ready", bus.D_READY, 1);
      end
      check("frame_count", bus.COUNT, i);
      send(words[i]);
    end
    ack_result(1, 1'b0);

    // 4: backpressure then ACK together with START
    words = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9};
    exp_q.push_back(fold(words));
    start_frame();
    for (int i = 0; i < 8; i++) send(words[i]);
    bus.D_VALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_sum", bus.SUM, 4'h9);
      check("bp_sv", bus.SUM_VALID, 1);
      check("bp_ready", bus.D_READY, 0);
      check("bp_busy", bus.BUSY, 1);
    end
    bus.SUM_ACK = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.SUM_ACK = 1'b0;
    bus.START = 1'b0;
    check("ackstart_busy", bus.BUSY, 0);
    check("ackstart_sv", bus.SUM_VALID, 0);
    tick();
    check("no_new_frame", bus.BUSY, 0);
    check("sum_kept", bus.SUM, 4'h9);

    // 5: abort mid-frame, then a clean frame
    start_frame();
    send(4'hA); send(4'h5); send(4'h3);
    bus.D_VALID = 1'b0;
    rst = 1'b1;
    tick();
    check("abort_count", bus.COUNT, 0);
    check("abort_busy", bus.BUSY, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) words[i] = 4'h7;
    exp_q.push_back(fold(words));
    start_frame();
    for (int i = 0; i < 8; i++) send(words[i]);
    ack_result(2, 1'b0);

    // randomized frames with stalls, stray STARTs and ack delays
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < 8; i++) words[i] = 4'($urandom_range(0, 15));
      exp_q.push_back(fold(words));
      start_frame();
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.D_VALID = 1'b0;
          bus.START = 1'($urandom_range(0, 1));
          tick();
          bus.START = 1'b0;
          check("rnd_stall_count", bus.COUNT, i);
        end
        send(words[i]);
      end
      ack_result($urandom_range(0, 4), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    // 6: single-word frames
    check("f1_idle_ready", bus1.D_READY, 0);
    bus1.START = 1'b1;
    tick();
    check("f1_accum", bus1.D_READY, 1);
    tick();
    bus1.START = 1'b0;
    check("f1_start_ignored", bus1.D_READY, 1);
    check("f1_sv_wait", bus1.SUM_VALID, 0);
    bus1.D = 4'hC;
    bus1.D_VALID = 1'b1;
    tick();
    bus1.D_VALID = 1'b0;
    check("f1_sum", bus1.SUM, 4'hC);
    check("f1_sv", bus1.SUM_VALID, 1);
    check("f1_count", bus1.COUNT, 0);
    bus1.START = 1'b1;
    tick();
    bus1.START = 1'b0;
    check("f1_done_start", bus1.SUM_VALID, 1);
    check("f1_done_busy", bus1.BUSY, 1);
    bus1.SUM_ACK = 1'b1;
    tick();
    bus1.SUM_ACK = 1'b0;
    check("f1_ack", bus1.BUSY, 0);
    check("f1_sum_kept", bus1.SUM, 4'hC);
    bus1.START = 1'b1;
    tick();
    bus1.START = 1'b0;
    bus1.D = 4'h5;
    bus1.D_VALID = 1'b1;
    tick();
    bus1.D_VALID = 1'b0;
    check("f1_sum2", bus1.SUM, 4'h5);

    tick(); tick();
    check("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
